// File: rtl/change_dispenser.sv
// change_dispenser: breaks a change amount into coins (largest first) across
// three tubes, ejecting one coin at a time through a one-hot eject/ack
// handshake. Tracks per-tube inventory and reports any unpayable remainder.
//
// Optional feature macro: CHANGE_JAM_TIMEOUT_EN
//   defined   -> ack timeout in EJECT sets sticky jam and parks the FSM in HALT
//   undefined -> EJECT waits indefinitely for eject_ack, jam stays 0
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for a request; refill honoured here only
// SELECT | pick largest coin <= remain with stock; miss ends request
// EJECT  | hold eject bit until eject_ack (or timeout when enabled)
// GAP    | one low cycle between coins
// DONE   | one-cycle done pulse
// HALT   | jammed; dead until reset
module change_dispenser #(
  parameter int COIN_A      = 20,
  parameter int COIN_B      = 10,
  parameter int COIN_C      = 5,
  parameter int INV_W       = 8,
  parameter int INV_INIT    = 10,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       change_valid,
  input  logic [6:0] return_change,
  input  logic       refill,
  input  logic       eject_ack,
  output logic       change_ready,
  output logic [2:0] eject,
  output logic       done,
  output logic [6:0] shortfall,
  output logic [2:0] low_stock,
  output logic       jam
);

`ifdef CHANGE_JAM_TIMEOUT_EN
  localparam bit JAM_EN = 1'b1;
`else
  localparam bit JAM_EN = 1'b0;
`endif

  localparam logic [6:0]       VAL_A    = COIN_A[6:0];
  localparam logic [6:0]       VAL_B    = COIN_B[6:0];
  localparam logic [6:0]       VAL_C    = COIN_C[6:0];
  localparam logic [INV_W-1:0] INV_LOAD = INV_INIT[INV_W-1:0];
  localparam logic [INV_W-1:0] INV_ONE  = {{(INV_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]       LOW_INIT = (INV_INIT == 0) ? 3'b111 : 3'b000;
  localparam int               TMO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_EJECT, S_GAP, S_DONE, S_HALT
  } state_t;

  state_t           state;
  logic [6:0]       remain;
  logic [INV_W-1:0] inv_a, inv_b, inv_c;
  logic [TMO_W-1:0] tmo_cnt;
  logic [2:0]       sel;
  logic [6:0]       eject_val;
  logic             tmo_hit;

  // Largest affordable coin that still has stock; zero means no coin fits.
  always_comb begin
    sel = 3'b000;
    if (remain >= VAL_A && inv_a != '0)      sel = 3'b100;
    else if (remain >= VAL_B && inv_b != '0) sel = 3'b010;
    else if (remain >= VAL_C && inv_c != '0) sel = 3'b001;
  end

  // Value of the coin currently being ejected.
  always_comb begin
    eject_val = '0;
    case (eject)
      3'b100:  eject_val = VAL_A;
      3'b010:  eject_val = VAL_B;
      3'b001:  eject_val = VAL_C;
      default: eject_val = '0;
    endcase
  end

  assign tmo_hit = JAM_EN && (tmo_cnt == '0);

  // Sequencer with registered outputs, inventory and ack-timeout down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      remain       <= '0;
      inv_a        <= INV_LOAD;
      inv_b        <= INV_LOAD;
      inv_c        <= INV_LOAD;
      tmo_cnt      <= TMO_LOAD;
      change_ready <= 1'b1;
      eject        <= 3'b000;
      done         <= 1'b0;
      shortfall    <= '0;
      low_stock    <= LOW_INIT;
      jam          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (change_valid) begin
            remain       <= return_change;
            shortfall    <= '0;
            change_ready <= 1'b0;
            state        <= S_SELECT;
          end else if (refill) begin
            inv_a     <= INV_LOAD;
            inv_b     <= INV_LOAD;
            inv_c     <= INV_LOAD;
            low_stock <= LOW_INIT;
          end
        end
        S_SELECT: begin
          if (sel != 3'b000) begin
            eject   <= sel;
            tmo_cnt <= TMO_LOAD;
            state   <= S_EJECT;
          end else begin
            shortfall <= remain;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_EJECT: begin
          if (eject_ack) begin
            remain <= remain - eject_val;
            if (eject[2]) begin
              inv_a <= inv_a - INV_ONE;
              if (inv_a == INV_ONE) low_stock[2] <= 1'b1;
            end
            if (eject[1]) begin
              inv_b <= inv_b - INV_ONE;
              if (inv_b == INV_ONE) low_stock[1] <= 1'b1;
            end
            if (eject[0]) begin
              inv_c <= inv_c - INV_ONE;
              if (inv_c == INV_ONE) low_stock[0] <= 1'b1;
            end
            eject <= 3'b000;
            state <= S_GAP;
          end else if (tmo_hit) begin
            eject     <= 3'b000;
            jam       <= 1'b1;
            shortfall <= remain;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_ONE;
          end
        end
        S_GAP: state <= S_SELECT;
        S_DONE: begin
          if (jam) begin
            state <= S_HALT;
          end else begin
            change_ready <= 1'b1;
            state        <= S_IDLE;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser. Trace index i = sample at the negedge
// i cycles after the acceptance edge (1 = SELECT cycle).
module tb_change_dispenser;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       change_valid = 1'b0;
  logic [6:0] return_change = '0;
  logic       refill = 1'b0;
  logic       eject_ack = 1'b0;
  logic       change_ready;
  logic [2:0] eject;
  logic       done;
  logic [6:0] shortfall;
  logic [2:0] low_stock;
  logic       jam;

  int checks = 0;
  int errors = 0;

  logic [2:0] tr[$];
  logic [2:0] coins[$];
  int         done_idx;
  int         done_cnt;
  bit         timed_out;
  logic       ready_at_end;

  change_dispenser dut (
    .clk(clk), .rst(rst), .change_valid(change_valid), .return_change(return_change),
    .refill(refill), .eject_ack(eject_ack), .change_ready(change_ready), .eject(eject),
    .done(done), .shortfall(shortfall), .low_stock(low_stock), .jam(jam)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b0; change_valid = 1'b0; refill = 1'b0; eject_ack = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Issue one request and record eject/done per cycle until one cycle after done.
  task automatic run_req(input logic [6:0] amt, input bit ack, input bit with_refill, input int max_cyc);
    tr.delete(); coins.delete();
    done_idx = -1; done_cnt = 0; timed_out = 1'b0;
    tr.push_back(3'b000);
    @(negedge clk);
    change_valid = 1'b1; return_change = amt; refill = with_refill;
    @(posedge clk);
    @(negedge clk);
    change_valid = 1'b0; refill = 1'b0;
    for (int i = 1; i <= max_cyc; i++) begin
      if (i > 1) @(negedge clk);
      tr.push_back(eject);
      if (eject != 3'b000) coins.push_back(eject);
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
      eject_ack = ack && (eject != 3'b000);
      ready_at_end = change_ready;
      if (done_idx >= 0 && i >= done_idx + 1) break;
    end
    if (done_idx < 0) timed_out = 1'b1;
    eject_ack = 1'b0;
  endtask

  function automatic bit back_to_back_high();
    for (int i = 0; i + 1 < tr.size(); i++)
      if (tr[i] != 3'b000 && tr[i+1] != 3'b000) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int first_eject_idx();
    for (int i = 0; i < tr.size(); i++)
      if (tr[i] != 3'b000) return i;
    return -1;
  endfunction

  function automatic int count_coin(input logic [2:0] c);
    int n = 0;
    foreach (coins[i]) if (coins[i] == c) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (change_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", change_ready); end
    checks++; if (eject !== 3'b000) begin errors++; $display("FAIL reset_eject got %b want 000", eject); end
    checks++; if (shortfall !== 7'd0) begin errors++; $display("FAIL reset_shortfall got %0d want 0", shortfall); end
    checks++; if (low_stock !== 3'b000) begin errors++; $display("FAIL reset_low_stock got %b want 000", low_stock); end
    checks++; if (jam !== 1'b0) begin errors++; $display("FAIL reset_jam got %b want 0", jam); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_mixed_coins();
    apply_reset();
    run_req(7'd35, 1'b1, 1'b0, 200);
    checks++; if (timed_out) begin errors++; $display("FAIL mixed_timeout got no done want done"); end
    checks++; if (coins.size() != 3) begin errors++; $display("FAIL mixed_count got %0d want 3", coins.size()); end
    else begin
      checks++; if (coins[0] !== 3'b100) begin errors++; $display("FAIL mixed_coin0 got %b want 100", coins[0]); end
      checks++; if (coins[1] !== 3'b010) begin errors++; $display("FAIL mixed_coin1 got %b want 010", coins[1]); end
      checks++; if (coins[2] !== 3'b001) begin errors++; $display("FAIL mixed_coin2 got %b want 001", coins[2]); end
    end
    checks++; if (back_to_back_high()) begin errors++; $display("FAIL mixed_gap got adjacent high want low cycle"); end
    checks++; if (first_eject_idx() != 2) begin errors++; $display("FAIL mixed_first_eject got %0d want 2", first_eject_idx()); end
    checks++; if (done_idx != 11) begin errors++; $display("FAIL mixed_done_idx got %0d want 11", done_idx); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL mixed_done_cnt got %0d want 1", done_cnt); end
    checks++; if (shortfall !== 7'd0) begin errors++; $display("FAIL mixed_shortfall got %0d want 0", shortfall); end
    checks++; if (ready_at_end !== 1'b1) begin errors++; $display("FAIL mixed_ready got %b want 1", ready_at_end); end
  endtask

  task automatic test_zero_change();
    run_req(7'd0, 1'b1, 1'b0, 50);
    checks++; if (done_idx != 2) begin errors++; $display("FAIL zero_done_idx got %0d want 2", done_idx); end
    checks++; if (coins.size() != 0) begin errors++; $display("FAIL zero_eject got %0d coins want 0", coins.size()); end
    checks++; if (shortfall !== 7'd0) begin errors++; $display("FAIL zero_shortfall got %0d want 0", shortfall); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_empty_tube();
    apply_reset();
    run_req(7'd100, 1'b1, 1'b0, 200);
    checks++; if (count_coin(3'b100) != 5 || coins.size() != 5) begin errors++; $display("FAIL empty_first100 got %0d A of %0d want 5 of 5", count_coin(3'b100), coins.size()); end
    checks++; if (low_stock !== 3'b000) begin errors++; $display("FAIL empty_low_mid got %b want 000", low_stock); end
    run_req(7'd100, 1'b1, 1'b0, 200);
    checks++; if (count_coin(3'b100) != 5 || coins.size() != 5) begin errors++; $display("FAIL empty_second100 got %0d A of %0d want 5 of 5", count_coin(3'b100), coins.size()); end
    checks++; if (low_stock !== 3'b100) begin errors++; $display("FAIL empty_low_a got %b want 100", low_stock); end
    run_req(7'd40, 1'b1, 1'b0, 200);
    checks++; if (count_coin(3'b010) != 4 || coins.size() != 4) begin errors++; $display("FAIL empty_40 got %0d B of %0d want 4 of 4", count_coin(3'b010), coins.size()); end
    checks++; if (shortfall !== 7'd0) begin errors++; $display("FAIL empty_shortfall got %0d want 0", shortfall); end
    checks++; if (low_stock !== 3'b100) begin errors++; $display("FAIL empty_low_keep got %b want 100", low_stock); end
    @(negedge clk); refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    checks++; if (low_stock !== 3'b000) begin errors++; $display("FAIL refill_low got %b want 000", low_stock); end
    run_req(7'd20, 1'b1, 1'b0, 100);
    checks++; if (coins.size() != 1 || coins[0] !== 3'b100) begin errors++; $display("FAIL refill_coin got %0d coins want one A", coins.size()); end
  endtask

  task automatic test_unpayable();
    apply_reset();
    run_req(7'd7, 1'b1, 1'b0, 100);
    checks++; if (coins.size() != 1 || coins[0] !== 3'b001) begin errors++; $display("FAIL unpay_coin got %0d coins want one C", coins.size()); end
    checks++; if (shortfall !== 7'd2) begin errors++; $display("FAIL unpay_shortfall got %0d want 2", shortfall); end
    checks++; if (done_idx != 5) begin errors++; $display("FAIL unpay_done_idx got %0d want 5", done_idx); end
  endtask

  task automatic test_valid_beats_refill();
    apply_reset();
    for (int k = 0; k < 9; k++) run_req(7'd5, 1'b1, 1'b0, 50);
    checks++; if (low_stock !== 3'b000) begin errors++; $display("FAIL collide_pre_low got %b want 000", low_stock); end
    run_req(7'd5, 1'b1, 1'b1, 50);
    checks++; if (coins.size() != 1 || coins[0] !== 3'b001) begin errors++; $display("FAIL collide_coin got %0d coins want one C", coins.size()); end
    checks++; if (low_stock !== 3'b001) begin errors++; $display("FAIL collide_low got %b want 001", low_stock); end
  endtask

`ifdef CHANGE_JAM_TIMEOUT_EN
  task automatic test_jam();
    int a_cycles = 0;
    apply_reset();
    run_req(7'd35, 1'b0, 1'b0, 200);
    foreach (tr[i]) if (tr[i] == 3'b100) a_cycles++;
    checks++; if (a_cycles != 64) begin errors++; $display("FAIL jam_eject_len got %0d want 64", a_cycles); end
    checks++; if (done_idx != 66) begin errors++; $display("FAIL jam_done_idx got %0d want 66", done_idx); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL jam_done_cnt got %0d want 1", done_cnt); end
    checks++; if (jam !== 1'b1) begin errors++; $display("FAIL jam_flag got %b want 1", jam); end
    checks++; if (shortfall !== 7'd35) begin errors++; $display("FAIL jam_shortfall got %0d want 35", shortfall); end
    @(negedge clk); change_valid = 1'b1; return_change = 7'd5;
    repeat (20) @(negedge clk);
    change_valid = 1'b0;
    checks++; if (change_ready !== 1'b0 || eject !== 3'b000) begin errors++; $display("FAIL jam_halt got ready %b eject %b want 0 000", change_ready, eject); end
    apply_reset();
    checks++; if (jam !== 1'b0 || change_ready !== 1'b1) begin errors++; $display("FAIL jam_clear got jam %b ready %b want 0 1", jam, change_ready); end
  endtask
`else
  task automatic test_stall_and_async_reset();
    apply_reset();
    @(negedge clk); change_valid = 1'b1; return_change = 7'd35;
    @(negedge clk); change_valid = 1'b0;
    repeat (100) @(negedge clk);
    change_valid = 1'b1; return_change = 7'd5; refill = 1'b1;
    @(negedge clk); change_valid = 1'b0; refill = 1'b0;
    @(negedge clk);
    checks++; if (eject !== 3'b100) begin errors++; $display("FAIL stall_eject got %b want 100", eject); end
    checks++; if (change_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", change_ready); end
    checks++; if (jam !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL stall_jam got jam %b done %b want 0 0", jam, done); end
    @(posedge clk); #2 rst = 1'b0;
    #1;
    checks++; if (eject !== 3'b000 || change_ready !== 1'b1) begin errors++; $display("FAIL async_reset got eject %b ready %b want 000 1", eject, change_ready); end
    @(negedge clk); rst = 1'b1;
    run_req(7'd5, 1'b1, 1'b0, 50);
    checks++; if (coins.size() != 1 || coins[0] !== 3'b001 || shortfall !== 7'd0) begin errors++; $display("FAIL post_reset got %0d coins shortfall %0d want 1 0", coins.size(), shortfall); end
  endtask
`endif

  initial begin
    test_reset();
    test_mixed_coins();
    test_zero_change();
    test_empty_tube();
    test_unpayable();
    test_valid_beats_refill();
`ifdef CHANGE_JAM_TIMEOUT_EN
    test_jam();
`else
    test_stall_and_async_reset();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
